matmul_stream_seq: RTL

MATMUL_STREAM_SEQ -- requirements
Module: matmul_stream_seq

---
 rtl/npu_pkg.sv | 15 +
 rtl/dot_pipe.sv | 70 +++++++
 rtl/matmul_stream_seq.sv | 133 +++++++++++++
 3 files changed

// File: rtl/npu_pkg.sv
// npu_pkg: shared NPU size defaults and the matmul sequencer state encoding
package npu_pkg;

    localparam int NPU_N      = 32;
    localparam int NPU_DATA_W = 8;
    localparam int NPU_ACC_W  = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } matmul_state_t;

endpackage

// File: rtl/dot_pipe.sv
// dot_pipe: N-way signed multiply (stage 1) and registered reduction to one sum (stage 2)
module dot_pipe
    import npu_pkg::*;
#(
    parameter int N      = NPU_N,
    parameter int DATA_W = NPU_DATA_W,
    parameter int ACC_W  = NPU_ACC_W,
    parameter int TAG_W  = 2 * $clog2(NPU_N)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     in_valid,
    input  logic [TAG_W-1:0]         in_tag,
    input  logic [N-1:0][DATA_W-1:0] a_vec,
    input  logic [N-1:0][DATA_W-1:0] b_vec,
    output logic                     out_valid,
    output logic [TAG_W-1:0]         out_tag,
    output logic signed [ACC_W-1:0]  out_sum
);

    localparam int PW = 2 * DATA_W;

    logic                    v1_q, v1_d, v2_q, v2_d;
    logic [TAG_W-1:0]        tag1_q, tag1_d, tag2_q, tag2_d;
    logic [N-1:0][PW-1:0]    prod_q, prod_d;
    logic signed [ACC_W-1:0] sum_q, sum_d, acc;
    logic signed [PW-1:0]    prod;

    // products and the sign-extended reduction; every stage holds while en is low
    always_comb begin
        prod_d = prod_q;
        prod   = '0;
        acc    = '0;
        for (int k = 0; k < N; k++) begin
            prod      = PW'($signed(a_vec[k])) * PW'($signed(b_vec[k]));
            prod_d[k] = en ? prod : prod_q[k];
            acc       = acc + ACC_W'($signed(prod_q[k]));
        end
        v1_d   = en ? in_valid : v1_q;
        tag1_d = en ? in_tag : tag1_q;
        v2_d   = en ? v1_q : v2_q;
        tag2_d = en ? tag1_q : tag2_q;
        sum_d  = en ? acc : sum_q;
    end

    // stage registers; valid bits travel alongside the data they qualify
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            tag1_q <= '0;
            tag2_q <= '0;
            prod_q <= '0;
            sum_q  <= '0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            tag1_q <= tag1_d;
            tag2_q <= tag2_d;
            prod_q <= prod_d;
            sum_q  <= sum_d;
        end
    end

    assign out_valid = v2_q;
    assign out_tag   = tag2_q;
    assign out_sum   = sum_q;

endmodule

// File: rtl/matmul_stream_seq.sv
// matmul_stream_seq: streams C = A*B row-major, one beat per cycle, with ready backpressure.
// Build option MATMUL_RELU_EN clamps negative results to zero before the output register.
module matmul_stream_seq
    import npu_pkg::*;
#(
    parameter int N      = NPU_N,
    parameter int DATA_W = NPU_DATA_W,
    parameter int ACC_W  = NPU_ACC_W
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic signed [N-1:0][N-1:0][DATA_W-1:0] matrixA,
    input  logic signed [N-1:0][N-1:0][DATA_W-1:0] matrixB,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic signed [ACC_W-1:0]                out_data,
    output logic [$clog2(N)-1:0]                   out_row,
    output logic [$clog2(N)-1:0]                   out_col,
    output logic                                   out_last,
    output logic                                   busy,
    output logic                                   done
);

    localparam int IW = $clog2(N);
    localparam int CW = 2 * IW;
    localparam logic [CW-1:0] CNT_LAST = CW'(N * N - 1);

    matmul_state_t           state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    en, accept, issue;
    logic [N-1:0][DATA_W-1:0] a_row, b_col;
    logic                    v2;
    logic [CW-1:0]           tag2;
    logic signed [ACC_W-1:0] sum2, res;
    logic                    out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic signed [ACC_W-1:0] out_data_q, out_data_d;
    logic [IW-1:0]           out_row_q, out_row_d, out_col_q, out_col_d;

    assign en     = !(out_valid_q && !out_ready);
    assign accept = out_valid_q && out_ready;
    assign issue  = state_q == RUN;

    // operand gather: row i of A and column j of B for the current issue index
    always_comb begin
        a_row = '0;
        b_col = '0;
        for (int k = 0; k < N; k++) begin
            a_row[k] = matrixA[cnt_q[CW-1:IW]][k];
            b_col[k] = matrixB[k][cnt_q[IW-1:0]];
        end
    end

    dot_pipe #(
        .N      (N),
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .TAG_W  (CW)
    ) u_dot (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (issue),
        .in_tag    (cnt_q),
        .a_vec     (a_row),
        .b_vec     (b_col),
        .out_valid (v2),
        .out_tag   (tag2),
        .out_sum   (sum2)
    );

    // sequencer: issue counter runs only in RUN and only while the pipeline advances
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) state_d = RUN;
            end
            RUN: if (en) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = DRAIN;
            end
            DRAIN: if (accept && out_last_q) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // output stage: loads when the beat it holds is gone, otherwise holds the payload
    always_comb begin
        res = sum2;
`ifdef MATMUL_RELU_EN
        res = sum2 < 0 ? '0 : sum2;
`endif
        out_valid_d = en ? v2 : out_valid_q;
        out_data_d  = en ? res : out_data_q;
        out_row_d   = en ? tag2[CW-1:IW] : out_row_q;
        out_col_d   = en ? tag2[IW-1:0] : out_col_q;
        out_last_d  = en ? (v2 && tag2 == CNT_LAST) : out_last_q;
    end

    // state, counter and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign out_last  = out_last_q;
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;

endmodule
